memory_reg: RTL and testbench
=============================

Name: memory_reg

Overview:
- Execute-to-memory pipeline register of the Y86-64 pipelined core.
- Sits directly downstream of the execute stage. It captures the execute-stage results (e_*) together with the pass-through E_* fields, and presents them as M_* to the memory stage.
- Handles the pipeline-control actions normal load, stall and bubble.
- Applies the conditional-move destination cancel.
- Keeps a sticky exception flag that the pipeline control logic uses.

Parameters:
- WORD_W, 64, data width of valE/valA.
- REG_W, 4, register-ID width.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- M_stall  input  1  hold current contents.
- M_bubble  input  1  load NOP bubble.
- e_stat  input  3  status from execute (SAOK=1, SADR=2, SINS=3, SHLT=4).
- E_icode  input  4  instruction code.
- e_Cnd  input  1  condition outcome from execute.
- e_valE  input  WORD_W  ALU result.
- E_valA  input  WORD_W  forwarded valA.
- E_dstE  input  REG_W  E destination before cmov cancel.
- E_dstM  input  REG_W  M destination.
- M_stat  output  3  registered status.
- M_icode  output  4  registered icode.
- M_Cnd  output  1  registered condition.
- M_valE  output  WORD_W  registered ALU result.
- M_valA  output  WORD_W  registered valA.
- M_dstE  output  REG_W  registered E destination.
- M_dstM  output  REG_W  registered M destination.
- M_exc_pending  output  1  sticky: an exceptional status has been loaded.

Behaviour:
- Single clock clk; reset rst_n is synchronous, active-low. All state updates occur on the rising edge of clk.
- Bubble state:
  - M_stat=SAOK(1), M_icode=INOP(1), M_Cnd=0.
  - M_valE=0, M_valA=0.
  - M_dstE=M_dstM=RNONE(0xF).
- Reset (rst_n=0 at an edge):
  - All M_* outputs take the bubble state.
  - M_exc_pending=0.
  - Reset overrides stall and bubble, and applies mid-operation with no residue.
- Per-edge priority: reset > M_bubble > M_stall > load.
- M_bubble=1: load the bubble state. M_exc_pending is unchanged.
- M_stall=1 (no bubble): all M_* outputs and M_exc_pending hold.
- Load (neither stall nor bubble):
  - M_stat←e_stat, M_icode←E_icode, M_Cnd←e_Cnd.
  - M_valE←e_valE, M_valA←E_valA, M_dstM←E_dstM.
  - M_dstE←RNONE if E_icode==IRRMOVQ(2) and e_Cnd==0; otherwise M_dstE←E_dstE.
- Latency: exactly 1 cycle from input to output on load. There is no combinational path from inputs to outputs.
- M_exc_pending:
  - Set on a load edge where e_stat is not SAOK.
  - Cleared only by reset.
  - A later SAOK load does not clear it.
  - A stall or bubble on the same edge as an exceptional e_stat does not set it.
- Unknown stat codes (0, 5-7) are treated as exceptional for M_exc_pending and are passed through unchanged.
- No arithmetic. Widths pass through unchanged.

Optional Feature:
- Macro MEMORY_REG_PERF_EN.
- Defined:
  - Adds outputs perf_bubbles (32) and perf_stalls (32).
  - perf_bubbles increments on each non-reset edge with M_bubble=1.
  - perf_stalls increments on each non-reset edge with M_stall=1 and M_bubble=0.
  - Both counters saturate at 0xFFFF_FFFF and clear on reset.
- Undefined: these ports and this logic are absent. Functional behaviour is otherwise identical.

Decomposition:
- Shared package y86_pkg holds:
  - status codes SAOK/SADR/SINS/SHLT;
  - icode constants (INOP=1, IRRMOVQ=2, others);
  - RNONE=4'hF;
  - a bubble-default constant set.
- One natural sub-module: sat_counter (32-bit saturating counter with synchronous clear). It is instantiated twice, only under MEMORY_REG_PERF_EN.

Test Plan:
- Reset: hold rst_n=0 for 2 edges with random inputs → M_icode=1, M_stat=1, M_dstE=M_dstM=0xF, M_valE=0, M_exc_pending=0.
- Normal load: e_stat=1, E_icode=6, e_valE=0x1234, E_dstE=3, E_dstM=0xF → next edge M_valE=0x1234, M_dstE=3, M_icode=6.
- Cmov cancel: E_icode=2, e_Cnd=0, E_dstE=5 → M_dstE=0xF. Same stimulus with e_Cnd=1 → M_dstE=5.
- Stall/bubble priority:
  - M_stall=1 for 3 edges while inputs change → outputs frozen.
  - M_stall=1 and M_bubble=1 together → bubble state loaded.
- Exception sticky: load e_stat=2 → M_stat=2, M_exc_pending=1. Then load e_stat=1 → M_exc_pending stays 1. Then rst_n=0 → it clears.
- Perf (MEMORY_REG_PERF_EN): 5 bubble edges and 3 stall-only edges → perf_bubbles=5, perf_stalls=3. Preload near max → saturates at 0xFFFF_FFFF.

Source files
------------

// File: rtl/y86_pkg.sv
// Shared Y86-64 pipeline constants: status codes, icodes, register IDs, bubble defaults.
// Latency: n/a (package only).
// Backpressure: n/a.
package y86_pkg;

    // Status codes
    localparam logic [2:0] SAOK = 3'd1;
    localparam logic [2:0] SADR = 3'd2;
    localparam logic [2:0] SINS = 3'd3;
    localparam logic [2:0] SHLT = 3'd4;

    // Instruction codes
    localparam logic [3:0] IHALT   = 4'h0;
    localparam logic [3:0] INOP    = 4'h1;
    localparam logic [3:0] IRRMOVQ = 4'h2;
    localparam logic [3:0] IIRMOVQ = 4'h3;
    localparam logic [3:0] IRMMOVQ = 4'h4;
    localparam logic [3:0] IMRMOVQ = 4'h5;
    localparam logic [3:0] IOPQ    = 4'h6;
    localparam logic [3:0] IJXX    = 4'h7;
    localparam logic [3:0] ICALL   = 4'h8;
    localparam logic [3:0] IRET    = 4'h9;
    localparam logic [3:0] IPUSHQ  = 4'hA;
    localparam logic [3:0] IPOPQ   = 4'hB;

    // "No register" ID
    localparam logic [3:0] RNONE = 4'hF;

    // Bubble (NOP) contents of a pipeline register
    localparam logic [2:0] BUBBLE_STAT  = SAOK;
    localparam logic [3:0] BUBBLE_ICODE = INOP;
    localparam logic       BUBBLE_CND   = 1'b0;
    localparam logic [3:0] BUBBLE_DST   = RNONE;

    // True when a status code is anything other than SAOK (unknown codes included)
    function automatic logic is_exc(input logic [2:0] stat);
        return stat != SAOK;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// 32-bit (parameterisable) saturating event counter, cleared by synchronous reset.
// Latency: count visible 1 cycle after the inc edge.
// Backpressure: none; sticks at all-ones once saturated.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next count: step by one unless already at the ceiling
    always_comb begin
        cnt_d = cnt_q;
        if (inc && (cnt_q != {W{1'b1}})) begin
            cnt_d = cnt_q + {{(W-1){1'b0}}, 1'b1};
        end
    end

    // Count register with synchronous clear
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/memory_reg.sv
// Execute-to-memory pipeline register with stall/bubble control, cmov dest cancel, sticky exception flag.
// Latency: 1 cycle on load; no combinational input-to-output path.
// Backpressure: M_stall holds all state; M_bubble (higher priority) loads a NOP. Optional MEMORY_REG_PERF_EN adds counters.
module memory_reg
    import y86_pkg::*;
#(
    parameter int WORD_W = 64,
    parameter int REG_W  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              M_stall,
    input  logic              M_bubble,
    input  logic [2:0]        e_stat,
    input  logic [3:0]        E_icode,
    input  logic              e_Cnd,
    input  logic [WORD_W-1:0] e_valE,
    input  logic [WORD_W-1:0] E_valA,
    input  logic [REG_W-1:0]  E_dstE,
    input  logic [REG_W-1:0]  E_dstM,
    output logic [2:0]        M_stat,
    output logic [3:0]        M_icode,
    output logic              M_Cnd,
    output logic [WORD_W-1:0] M_valE,
    output logic [WORD_W-1:0] M_valA,
    output logic [REG_W-1:0]  M_dstE,
    output logic [REG_W-1:0]  M_dstM,
    output logic              M_exc_pending
`ifdef MEMORY_REG_PERF_EN
    ,
    output logic [31:0]       perf_bubbles,
    output logic [31:0]       perf_stalls
`endif
);

    localparam logic [REG_W-1:0] DST_NONE = REG_W'(BUBBLE_DST);

    logic [2:0]        stat_q,  stat_d;
    logic [3:0]        icode_q, icode_d;
    logic              cnd_q,   cnd_d;
    logic [WORD_W-1:0] val_e_q, val_e_d;
    logic [WORD_W-1:0] val_a_q, val_a_d;
    logic [REG_W-1:0]  dst_e_q, dst_e_d;
    logic [REG_W-1:0]  dst_m_q, dst_m_d;
    logic              exc_q,   exc_d;

    logic              do_load;
    logic              cmov_cancel;

    assign do_load     = !M_bubble && !M_stall;
    // A not-taken conditional move must not write its destination
    assign cmov_cancel = (E_icode == IRRMOVQ) && !e_Cnd;

    // Next-state selection: bubble beats stall beats load
    always_comb begin
        stat_d  = stat_q;
        icode_d = icode_q;
        cnd_d   = cnd_q;
        val_e_d = val_e_q;
        val_a_d = val_a_q;
        dst_e_d = dst_e_q;
        dst_m_d = dst_m_q;
        exc_d   = exc_q;
        if (M_bubble) begin
            stat_d  = BUBBLE_STAT;
            icode_d = BUBBLE_ICODE;
            cnd_d   = BUBBLE_CND;
            val_e_d = '0;
            val_a_d = '0;
            dst_e_d = DST_NONE;
            dst_m_d = DST_NONE;
        end else if (do_load) begin
            stat_d  = e_stat;
            icode_d = E_icode;
            cnd_d   = e_Cnd;
            val_e_d = e_valE;
            val_a_d = E_valA;
            dst_e_d = cmov_cancel ? DST_NONE : E_dstE;
            dst_m_d = E_dstM;
            // Only an actually-loaded exceptional status arms the sticky flag
            exc_d   = exc_q || is_exc(e_stat);
        end
    end

    // Pipeline register state; reset forces the bubble contents and clears the flag
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stat_q  <= BUBBLE_STAT;
            icode_q <= BUBBLE_ICODE;
            cnd_q   <= BUBBLE_CND;
            val_e_q <= '0;
            val_a_q <= '0;
            dst_e_q <= DST_NONE;
            dst_m_q <= DST_NONE;
            exc_q   <= 1'b0;
        end else begin
            stat_q  <= stat_d;
            icode_q <= icode_d;
            cnd_q   <= cnd_d;
            val_e_q <= val_e_d;
            val_a_q <= val_a_d;
            dst_e_q <= dst_e_d;
            dst_m_q <= dst_m_d;
            exc_q   <= exc_d;
        end
    end

    assign M_stat        = stat_q;
    assign M_icode       = icode_q;
    assign M_Cnd         = cnd_q;
    assign M_valE        = val_e_q;
    assign M_valA        = val_a_q;
    assign M_dstE        = dst_e_q;
    assign M_dstM        = dst_m_q;
    assign M_exc_pending = exc_q;

`ifdef MEMORY_REG_PERF_EN
    logic stall_only;
    assign stall_only = M_stall && !M_bubble;

    sat_counter #(.W(32)) u_bubble_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (M_bubble),
        .cnt   (perf_bubbles)
    );

    sat_counter #(.W(32)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (stall_only),
        .cnt   (perf_stalls)
    );
`endif

endmodule

// File: tb/tb_memory_reg.sv
// Bench for memory_reg: scoreboard of expected register contents, one entry per clock edge.
// Latency: expected value pushed at drive time, popped 1 cycle later.
// Backpressure: stall/bubble/reset exercised directed and random.
module tb_memory_reg;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        M_stall, M_bubble;
    logic [2:0]  e_stat;
    logic [3:0]  E_icode;
    logic        e_Cnd;
    logic [63:0] e_valE, E_valA;
    logic [3:0]  E_dstE, E_dstM;
    logic [2:0]  M_stat;
    logic [3:0]  M_icode;
    logic        M_Cnd;
    logic [63:0] M_valE, M_valA;
    logic [3:0]  M_dstE, M_dstM;
    logic        M_exc_pending;
`ifdef MEMORY_REG_PERF_EN
    logic [31:0] perf_bubbles, perf_stalls;
`endif

    always #5 clk = ~clk;

    memory_reg #(.WORD_W(64), .REG_W(4)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .M_stall       (M_stall),
        .M_bubble      (M_bubble),
        .e_stat        (e_stat),
        .E_icode       (E_icode),
        .e_Cnd         (e_Cnd),
        .e_valE        (e_valE),
        .E_valA        (E_valA),
        .E_dstE        (E_dstE),
        .E_dstM        (E_dstM),
        .M_stat        (M_stat),
        .M_icode       (M_icode),
        .M_Cnd         (M_Cnd),
        .M_valE        (M_valE),
        .M_valA        (M_valA),
        .M_dstE        (M_dstE),
        .M_dstM        (M_dstM),
        .M_exc_pending (M_exc_pending)
`ifdef MEMORY_REG_PERF_EN
        ,
        .perf_bubbles  (perf_bubbles),
        .perf_stalls   (perf_stalls)
`endif
    );

    typedef struct packed {
        logic [2:0]  stat;
        logic [3:0]  icode;
        logic        cnd;
        logic [63:0] vale;
        logic [63:0] vala;
        logic [3:0]  dste;
        logic [3:0]  dstm;
        logic        exc;
        logic [31:0] pb;
        logic [31:0] ps;
    } exp_t;

    exp_t sb_q[$];
    exp_t mdl;
    int   n_vec = 0;
    int   n_bad = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_vec++;
        if (obs !== exp_v) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    function automatic exp_t bubble_of(input exp_t cur);
        exp_t r = cur;
        r.stat = 3'd1; r.icode = 4'd1; r.cnd = 1'b0;
        r.vale = '0;   r.vala  = '0;   r.dste = 4'hF; r.dstm = 4'hF;
        return r;
    endfunction

    // Drive one edge of stimulus, predict the result, then compare after the edge
    task automatic cyc(input logic rst, input logic bub, input logic stl,
                       input logic [2:0] st, input logic [3:0] ic, input logic cnd,
                       input logic [63:0] ve, input logic [63:0] va,
                       input logic [3:0] de, input logic [3:0] dm);
        exp_t nx;
        exp_t got;
        rst_n = rst; M_bubble = bub; M_stall = stl;
        e_stat = st; E_icode = ic; e_Cnd = cnd;
        e_valE = ve; E_valA = va; E_dstE = de; E_dstM = dm;
        nx = mdl;
        if (!rst) begin
            nx = bubble_of(mdl);
            nx.exc = 1'b0; nx.pb = '0; nx.ps = '0;
        end else if (bub) begin
            nx = bubble_of(mdl);
            if (mdl.pb != 32'hFFFF_FFFF) nx.pb = mdl.pb + 1;
        end else if (stl) begin
            if (mdl.ps != 32'hFFFF_FFFF) nx.ps = mdl.ps + 1;
        end else begin
            nx.stat = st; nx.icode = ic; nx.cnd = cnd;
            nx.vale = ve; nx.vala = va; nx.dstm = dm;
            nx.dste = (ic == 4'd2 && !cnd) ? 4'hF : de;
            if (st != 3'd1) nx.exc = 1'b1;
        end
        mdl = nx;
        sb_q.push_back(nx);
        @(posedge clk);
        #1;
        got = sb_q.pop_front();
        check("stat",  {61'd0, M_stat},  {61'd0, got.stat});
        check("icode", {60'd0, M_icode}, {60'd0, got.icode});
        check("cnd",   {63'd0, M_Cnd},   {63'd0, got.cnd});
        check("valE",  M_valE, got.vale);
        check("valA",  M_valA, got.vala);
        check("dstE",  {60'd0, M_dstE},  {60'd0, got.dste});
        check("dstM",  {60'd0, M_dstM},  {60'd0, got.dstm});
        check("exc",   {63'd0, M_exc_pending}, {63'd0, got.exc});
`ifdef MEMORY_REG_PERF_EN
        check("perf_bubbles", {32'd0, perf_bubbles}, {32'd0, got.pb});
        check("perf_stalls",  {32'd0, perf_stalls},  {32'd0, got.ps});
`endif
    endtask

    task automatic rnd_cyc(input logic rst, input logic bub, input logic stl);
        cyc(rst, bub, stl, 3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)),
            1'($urandom_range(0, 1)), {$urandom, $urandom}, {$urandom, $urandom},
            4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
    endtask

    initial begin
        mdl = '0;
        // Reset for two edges with random data
        rnd_cyc(1'b0, 1'b0, 1'b0);
        rnd_cyc(1'b0, 1'b1, 1'b1);
        check("rst_icode_const", {60'd0, M_icode}, 64'd1);
        check("rst_dstE_const",  {60'd0, M_dstE},  64'hF);

        // Normal load
        cyc(1'b1, 1'b0, 1'b0, 3'd1, 4'd6, 1'b1, 64'h1234, 64'h55, 4'd3, 4'hF);
        check("load_valE_const", M_valE, 64'h1234);
        check("load_dstE_const", {60'd0, M_dstE}, 64'd3);

        // Cmov cancel, then taken cmov
        cyc(1'b1, 1'b0, 1'b0, 3'd1, 4'd2, 1'b0, 64'h9, 64'h8, 4'd5, 4'hF);
        check("cmov_cancel_const", {60'd0, M_dstE}, 64'hF);
        cyc(1'b1, 1'b0, 1'b0, 3'd1, 4'd2, 1'b1, 64'h9, 64'h8, 4'd5, 4'hF);
        check("cmov_taken_const", {60'd0, M_dstE}, 64'd5);
        // Non-cmov icode with Cnd=0 keeps its destination
        cyc(1'b1, 1'b0, 1'b0, 3'd1, 4'd3, 1'b0, 64'h7, 64'h6, 4'd4, 4'd2);

        // Stall for three edges while inputs change, with an exceptional stat offered
        rnd_cyc(1'b1, 1'b0, 1'b1);
        cyc(1'b1, 1'b0, 1'b1, 3'd3, 4'd5, 1'b1, 64'hAA, 64'hBB, 4'd1, 4'd1);
        rnd_cyc(1'b1, 1'b0, 1'b1);
        // Stall and bubble together: bubble wins
        cyc(1'b1, 1'b1, 1'b1, 3'd2, 4'd4, 1'b1, 64'hCC, 64'hDD, 4'd1, 4'd2);
        check("bubble_valA_const", M_valA, 64'd0);

        // Exceptional load sets the sticky flag, SAOK load and bubble keep it
        cyc(1'b1, 1'b0, 1'b0, 3'd2, 4'd5, 1'b0, 64'h100, 64'h200, 4'hF, 4'd7);
        check("exc_set_const", {63'd0, M_exc_pending}, 64'd1);
        cyc(1'b1, 1'b0, 1'b0, 3'd1, 4'd6, 1'b0, 64'h1, 64'h2, 4'd1, 4'hF);
        cyc(1'b1, 1'b1, 1'b0, 3'd1, 4'd6, 1'b0, 64'h1, 64'h2, 4'd1, 4'hF);
        check("exc_sticky_const", {63'd0, M_exc_pending}, 64'd1);
        rnd_cyc(1'b0, 1'b0, 1'b0);
        check("exc_clr_const", {63'd0, M_exc_pending}, 64'd0);

        // Unknown stat code is passed through and counts as exceptional
        cyc(1'b1, 1'b0, 1'b0, 3'd6, 4'd1, 1'b0, 64'h3, 64'h4, 4'd2, 4'd3);

        // Counter pattern: five bubbles, three stall-only edges
        for (int i = 0; i < 5; i++) rnd_cyc(1'b1, 1'b1, 1'($urandom_range(0, 1)));
        for (int i = 0; i < 3; i++) rnd_cyc(1'b1, 1'b0, 1'b1);
        rnd_cyc(1'b1, 1'b0, 1'b0);

        // Random mix including mid-stream resets
        for (int i = 0; i < 60; i++) begin
            rnd_cyc(1'($urandom_range(0, 9) != 0), 1'($urandom_range(0, 4) == 0),
                    1'($urandom_range(0, 3) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
